// File: rtl/mult_avalon_engine.sv
// Avalon-MM slave wrapping a radix-2 shift-add multiplier (signed or unsigned).
// Register and bus responses are registered; irq is a level derived from done and irq_en.
module mult_avalon_engine #(
    parameter int DATA_W         = 32,
    parameter bit IRQ_EN_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic [1:0]        response,
    output logic              writeresponsevalid,
    output logic              irq
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0]   opa_q, opb_q, mplier_q, abs_a, abs_b;
    logic [2*DATA_W-1:0] mcand_q, acc_q, res_q;
    logic [CW-1:0]       cnt_q;
    logic                sgn_q, irq_en_q, start_q, neg_q;
    logic                busy, done;

    // start_q covers the cycle between accepting start and entering BUSY,
    // so the engine already reports busy (and not done) on the accepting edge.
    assign busy = start_q | (state_q == BUSY) | (state_q == SIGN);
    assign done = (state_q == DONE) & ~start_q;
    assign irq  = done & irq_en_q;

    assign abs_a = (sgn_q && opa_q[DATA_W-1]) ? -opa_q : opa_q;
    assign abs_b = (sgn_q && opb_q[DATA_W-1]) ? -opb_q : opb_q;

    logic       wr_opa, wr_opb, wr_ctrl, wr_start, wr_clr;
    logic [1:0] wresp, rresp;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        wr_opa = 1'b0; wr_opb = 1'b0; wr_ctrl = 1'b0; wr_start = 1'b0; wr_clr = 1'b0;
        wresp = OKAY;
        if (write) begin
            case (address)
                3'd0: if (busy) wresp = SLVERR; else wr_opa = 1'b1;
                3'd1: if (busy) wresp = SLVERR; else wr_opb = 1'b1;
                3'd2: if (writedata[0] && busy) wresp = SLVERR;
                      else begin wr_ctrl = 1'b1; wr_start = writedata[0]; end
                3'd3: if (writedata[1]) wr_clr = done; else wresp = DECERR;
                default: wresp = DECERR;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        rresp = OKAY;
        case (address)
            3'd0: rdata = opa_q;
            3'd1: rdata = opb_q;
            3'd2: rdata[2:1] = {irq_en_q, sgn_q};
            3'd3: rdata[1:0] = {done, busy};
            3'd4: rdata = res_q[DATA_W-1:0];
            3'd5: rdata = res_q[2*DATA_W-1:DATA_W];
            default: rresp = DECERR;
        endcase
        // A read colliding with a write loses: write is serviced, read errors.
        if (write) begin
            rdata = '0;
            rresp = SLVERR;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_q) state_d = BUSY;
            BUSY: if (cnt_q == CW'(DATA_W - 1)) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: if (start_q) state_d = BUSY;
                  else if (wr_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sgn_q    <= 1'b0;
            irq_en_q <= IRQ_EN_DEFAULT;
            start_q  <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            start_q <= wr_start;
            if (wr_opa) opa_q <= writedata;
            if (wr_opb) opb_q <= writedata;
            if (wr_ctrl) begin
                sgn_q    <= writedata[1];
                irq_en_q <= writedata[2];
            end
            if (start_q) begin
                neg_q    <= sgn_q & (opa_q[DATA_W-1] ^ opb_q[DATA_W-1]);
                mcand_q  <= {{DATA_W{1'b0}}, abs_a};
                mplier_q <= abs_b;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == BUSY) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end else if (state_q == SIGN) begin
                res_q <= neg_q ? -acc_q : acc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata           <= '0;
            readdatavalid      <= 1'b0;
            response           <= OKAY;
            writeresponsevalid <= 1'b0;
        end else begin
            readdatavalid      <= read;
            writeresponsevalid <= write;
            readdata           <= read ? rdata : '0;
            response           <= read ? rresp : (write ? wresp : OKAY);
        end
    end
endmodule

// File: doc/mult_avalon_engine.md
MULT_AVALON_ENGINE -- requirements
Module: mult_avalon_engine

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits; legal range 8..64.
REQ-002 Parameter IRQ_EN_DEFAULT, default 0, reset value of CTRL.irq_en.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 write  input  1  Avalon-MM write strobe.
REQ-007 writedata  input  DATA_W  write data.
REQ-008 read  input  1  Avalon-MM read strobe.
REQ-009 readdata  output  DATA_W  read data, valid with readdatavalid.
REQ-010 readdatavalid  output  1  one-cycle pulse, read data valid.
REQ-011 response  output  2  00 OKAY, 10 SLVERR, 11 DECODEERROR.
REQ-012 writeresponsevalid  output  1  one-cycle pulse, write response valid.
REQ-013 irq  output  1  level interrupt = STATUS.done AND CTRL.irq_en.

Function
REQ-014 Register map: 0 OPA (RW), 1 OPB (RW), 2 CTRL (W: bit0 start, bit1 signed, bit2 irq_en; R: bits2:1, bit0 reads 0), 3 STATUS (R: bit0 busy, bit1 done; W1C bit1), 4 RES_LO (RO), 5 RES_HI (RO), 6-7 unmapped.
REQ-015 Every accepted write produces writeresponsevalid=1 for exactly one cycle on the edge after write is sampled; every read produces readdatavalid=1 for exactly one cycle on the edge after read is sampled.
REQ-016 write and read asserted in the same cycle: write is serviced and responded; read gets response 10, readdata 0.
REQ-017 FSM states IDLE, BUSY, SIGN, DONE; IDLE->BUSY on CTRL write with start=1; BUSY->SIGN after exactly DATA_W BUSY cycles; SIGN->DONE after one cycle; DONE->BUSY on new start; DONE->IDLE on W1C of STATUS.done.
REQ-018 On start: latch signed mode; capture |OPA|,|OPB| when signed else raw operands; clear accumulator and bit counter.
REQ-019 BUSY: radix-2 shift-add, one multiplier bit per cycle, LSB first, 2*DATA_W accumulator, no overflow possible.
REQ-020 SIGN: negate accumulator iff signed and OPA[MSB] XOR OPB[MSB]; write 2*DATA_W result to RES_HI:RES_LO.
REQ-021 Latency: done=1 visible exactly DATA_W+2 rising edges after the edge accepting start; busy=1 in BUSY and SIGN only.
REQ-022 Write to OPA, OPB or CTRL.start=1 while busy: response 10, register and computation unchanged.
REQ-023 Write to STATUS/RES_LO/RES_HI (other than STATUS W1C) or read of unmapped address: response 11; reads return 0; no state change.
REQ-024 RES_LO/RES_HI hold last result until next SIGN cycle; reads during BUSY return previous result with response 00.
REQ-025 Start with done=1 clears done on the accepting edge.

Reset
REQ-026 reset_n low: OPA, OPB, RES_LO, RES_HI, accumulator, counter = 0; CTRL.signed=0; CTRL.irq_en=IRQ_EN_DEFAULT; FSM=IDLE.
REQ-027 During reset: readdata=0, readdatavalid=0, response=00, writeresponsevalid=0, irq=0.
REQ-028 Reset asserted mid-operation aborts immediately; no result written; after release busy=0, done=0.
REQ-029 Strobes sampled in the first cycle after reset_n deasserts are serviced normally.

Verification (DATA_W=32)
REQ-030 OPA=7, OPB=6, CTRL=0x1 -> done at edge +34; RES_LO=42, RES_HI=0; busy=1 for 34 cycles.
REQ-031 OPA=0xFFFFFFFD, OPB=5, CTRL=0x3 -> RES_LO=0xFFFFFFF1, RES_HI=0xFFFFFFFF.
REQ-032 OPA=OPB=0xFFFFFFFF, CTRL=0x1 -> RES_HI=0xFFFFFFFE, RES_LO=0x00000001.
REQ-033 Write OPA=9 at busy cycle 5 -> response 10, OPA unchanged, result unaffected.
REQ-034 CTRL=0x5 then reset_n low at busy cycle 10 -> all outputs 0, RES_LO=0, irq=0; restart after release yields correct product.
REQ-035 Read address 6 -> response 11, readdata 0; W1C STATUS=0x2 after done -> done=0, irq=0, FSM IDLE.
